// File: rtl/if_stage_if.sv
// if_stage_if: decode-side handshake and SRAM-like instruction port of the fetch stage
interface if_stage_if;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  ds_allowin, br_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_wr, inst_sram_size,
               inst_sram_wstrb, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output ds_allowin, br_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_wr, inst_sram_size,
               inst_sram_wstrb, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with one outstanding SRAM request and delay-slot branching
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input logic        clk,
    input logic        reset,
    if_stage_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      fsm;
    logic [31:0] req_addr;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic [31:0] br_pend_target;
    logic [31:0] nextpc;
    logic        fs_valid;
    logic        br_pend;
    logic        drop;
    logic        br_live;
    logic        issue;

    // Next fetch address: a captured branch wins, then a live resolved branch, else sequential
    always_comb begin
        br_live = bus.br_bus[32] & ~bus.br_bus[33];
        issue   = (fsm == S_IDLE) & ~drop & (~fs_valid | bus.ds_allowin);
        nextpc  = br_pend ? br_pend_target : br_live ? bus.br_bus[31:0] : fs_pc + 32'd4;
    end

    // Fetch FSM, branch capture and decode-side valid; drop outlives reset to swallow a stale word
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm      <= S_IDLE;
            fs_valid <= 1'b0;
            br_pend  <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
            req_addr <= RESET_PC;
            fs_inst  <= 32'd0;
            drop     <= (drop | (fsm == S_WAIT)) & ~bus.inst_sram_data_ok;
        end else begin
            if (br_live) begin
                br_pend        <= 1'b1;
                br_pend_target <= bus.br_bus[31:0];
            end
            if (fs_valid & bus.ds_allowin) fs_valid <= 1'b0;
            if (drop & bus.inst_sram_data_ok) drop <= 1'b0;
            case (fsm)
                S_IDLE: if (issue) begin
                    fsm      <= S_REQ;
                    req_addr <= nextpc;
                    br_pend  <= 1'b0;
                end
                S_REQ: if (bus.inst_sram_addr_ok) begin
                    fsm   <= S_WAIT;
                    fs_pc <= req_addr;
                end
                S_WAIT: if (bus.inst_sram_data_ok) begin
                    fsm      <= S_IDLE;
                    fs_inst  <= bus.inst_sram_rdata;
                    fs_valid <= 1'b1;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    assign bus.fs_to_ds_valid  = fs_valid;
    assign bus.fs_to_ds_bus    = {fs_inst, fs_pc};
    assign bus.inst_sram_req   = (fsm == S_REQ);
    assign bus.inst_sram_addr  = req_addr;
    assign bus.inst_sram_wr    = 1'b0;
    assign bus.inst_sram_size  = 2'd2;
    assign bus.inst_sram_wstrb = 4'b0;
    assign bus.inst_sram_wdata = 32'd0;
endmodule
